// File: rtl/control_sequencer.sv
// control_sequencer: T0..T6 timing/control unit of the basic computer (IR decode, bus select, strobes)
// Define INTERRUPT_EN to add I/O instructions, ien/r_ff and the RT0..RT2 interrupt cycle.
module control_sequencer #(
    parameter int SC_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     ir_outdata,
    input  logic            ac_sign,
    input  logic            ac_zero,
    input  logic            e_flag,
    input  logic            dr_zero,
    input  logic            fgi,
    input  logic            fgo,
    output logic [2:0]      bus_code,
    output logic            ar_ld,
    output logic            ar_inc,
    output logic            ar_clr,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            pc_clr,
    output logic            dr_ld,
    output logic            dr_inc,
    output logic            ir_ld,
    output logic            tr_ld,
    output logic            mem_wr,
    output logic [3:0]      alu_op,
    output logic [SC_W-1:0] sc,
    output logic            halted
);
    typedef enum logic [SC_W-1:0] {T0, T1, T2, T3, T4, T5, T6} state_t;
    state_t sc_q, sc_d;
    logic i_ff, i_d, halt_d;
    logic [2:0] d_q, d_d;
`ifdef INTERRUPT_EN
    logic ien, ien_d, r_ff, r_d;
`else
    logic unused_flags;
    assign unused_flags = fgi ^ fgo;
`endif
    assign sc = sc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_q   <= T0;
            i_ff   <= 1'b0;
            d_q    <= 3'd0;
            halted <= 1'b0;
`ifdef INTERRUPT_EN
            ien    <= 1'b0;
            r_ff   <= 1'b0;
`endif
        end else begin
            sc_q   <= sc_d;
            i_ff   <= i_d;
            d_q    <= d_d;
            halted <= halt_d;
`ifdef INTERRUPT_EN
            ien    <= ien_d;
            r_ff   <= r_d;
`endif
        end
    end

    always_comb begin
        sc_d   = T0;
        i_d    = i_ff;
        d_d    = d_q;
        halt_d = halted;
`ifdef INTERRUPT_EN
        ien_d  = ien;
        r_d    = r_ff;
`endif
        bus_code = 3'b000;
        {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ir_ld, tr_ld, mem_wr} = '0;
        alu_op = 4'h0;
        if (!halted) begin
`ifdef INTERRUPT_EN
            if (ien && (fgi || fgo) && sc_q > T2)
                r_d = 1'b1;
            // a pending interrupt replaces the fetch states with RT0..RT2
            if (r_ff && sc_q <= T2) begin
                case (sc_q)
                    T0: begin
                        ar_clr = 1'b1; bus_code = 3'b010; tr_ld = 1'b1; sc_d = T1;
                    end
                    T1: begin
                        bus_code = 3'b110; mem_wr = 1'b1; pc_clr = 1'b1; sc_d = T2;
                    end
                    default: begin
                        pc_inc = 1'b1; ien_d = 1'b0; r_d = 1'b0;
                    end
                endcase
            end else
`endif
            case (sc_q)
                T0: begin
                    bus_code = 3'b010; ar_ld = 1'b1; sc_d = T1;
                end
                T1: begin
                    bus_code = 3'b111; ir_ld = 1'b1; pc_inc = 1'b1; sc_d = T2;
                end
                T2: begin
                    bus_code = 3'b101; ar_ld = 1'b1; sc_d = T3;
                    i_d = ir_outdata[15];
                    d_d = ir_outdata[14:12];
                end
                T3: begin
                    if (d_q != 3'd7) begin
                        bus_code = i_ff ? 3'b111 : 3'b000;
                        ar_ld    = i_ff;
                        sc_d     = T4;
                    end else if (!i_ff) begin
                        if      (ir_outdata[11]) alu_op = 4'h4;
                        else if (ir_outdata[10]) alu_op = 4'h5;
                        else if (ir_outdata[9])  alu_op = 4'h6;
                        else if (ir_outdata[8])  alu_op = 4'h7;
                        else if (ir_outdata[7])  alu_op = 4'h8;
                        else if (ir_outdata[6])  alu_op = 4'h9;
                        else if (ir_outdata[5])  alu_op = 4'hA;
                        else if (ir_outdata[4])  pc_inc = !ac_sign;
                        else if (ir_outdata[3])  pc_inc = ac_sign;
                        else if (ir_outdata[2])  pc_inc = ac_zero;
                        else if (ir_outdata[1])  pc_inc = !e_flag;
                        else if (ir_outdata[0])  halt_d = 1'b1;
                    end
`ifdef INTERRUPT_EN
                    else begin
                        if      (ir_outdata[11]) alu_op = 4'hB;
                        else if (ir_outdata[10]) alu_op = 4'hC;
                        else if (ir_outdata[9])  pc_inc = fgi;
                        else if (ir_outdata[8])  pc_inc = fgo;
                        else if (ir_outdata[7])  ien_d  = 1'b1;
                        else if (ir_outdata[6])  ien_d  = 1'b0;
                    end
`endif
                end
                T4: begin
                    case (d_q)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            bus_code = 3'b111; dr_ld = 1'b1; sc_d = T5;
                        end
                        3'd3: begin
                            bus_code = 3'b100; mem_wr = 1'b1;
                        end
                        3'd4: begin
                            bus_code = 3'b001; pc_ld = 1'b1;
                        end
                        3'd5: begin
                            bus_code = 3'b010; mem_wr = 1'b1; ar_inc = 1'b1; sc_d = T5;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (d_q)
                        3'd0, 3'd1, 3'd2: alu_op = {1'b0, d_q} + 4'd1;
                        3'd5: begin
                            bus_code = 3'b001; pc_ld = 1'b1;
                        end
                        3'd6: begin
                            dr_inc = 1'b1; sc_d = T6;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    bus_code = 3'b011; mem_wr = 1'b1; pc_inc = dr_zero;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction walk-through of control_sequencer
// Covers fetch, memory-reference, register-reference, HLT, reset abort and (with INTERRUPT_EN) the interrupt cycle.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        ac_sign = 1'b0, ac_zero = 1'b0, e_flag = 1'b0, dr_zero = 1'b0, fgi = 1'b0, fgo = 1'b0;
    logic [2:0]  bus_code;
    logic        ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ir_ld, tr_ld, mem_wr;
    logic [3:0]  alu_op;
    logic [2:0]  sc;
    logic        halted;
    int          vec = 0, miss = 0;
    localparam logic [10:0] ARL = 11'h400, ARI = 11'h200, ARC = 11'h100, PCL = 11'h080, PCI = 11'h040,
                            PCC = 11'h020, DRL = 11'h010, DRI = 11'h008, IRL = 11'h004, TRL = 11'h002,
                            MW  = 11'h001, NONE = 11'h000;

    control_sequencer dut (
        .clk(clk), .reset(reset), .ir_outdata(ir), .ac_sign(ac_sign), .ac_zero(ac_zero),
        .e_flag(e_flag), .dr_zero(dr_zero), .fgi(fgi), .fgo(fgo), .bus_code(bus_code),
        .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_clr(pc_clr), .dr_ld(dr_ld), .dr_inc(dr_inc), .ir_ld(ir_ld), .tr_ld(tr_ld),
        .mem_wr(mem_wr), .alu_op(alu_op), .sc(sc), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {sc, bus_code, ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc,
                  ir_ld, tr_ld, mem_wr, alu_op};

    task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
        vec++;
        assert (o === e) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] s, input logic [2:0] b,
                        input logic [10:0] st, input logic [3:0] a);
        #2 chk(tag, obs, {s, b, st, a});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step({tag, " T0"}, 3'd0, 3'b010, ARL, 4'h0);
        step({tag, " T1"}, 3'd1, 3'b111, IRL | PCI, 4'h0);
        step({tag, " T2"}, 3'd2, 3'b101, ARL, 4'h0);
    endtask

    task automatic rref(input string tag, input logic [15:0] i, input logic [2:0] f,
                        input logic [10:0] st, input logic [3:0] a);
        ir = i;
        {ac_sign, ac_zero, e_flag} = f;
        fetch(tag);
        step({tag, " T3"}, 3'd3, 3'b000, st, a);
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("reset halted", {20'd0, halted}, 21'd0);
        #0;
        // LDA direct
        ir = 16'h2010;
        fetch("lda");
        step("lda T3", 3'd3, 3'b000, NONE, 4'h0);
        step("lda T4", 3'd4, 3'b111, DRL, 4'h0);
        step("lda T5", 3'd5, 3'b000, NONE, 4'h3);
        // ADD direct
        ir = 16'h1010;
        fetch("add");
        step("add T3", 3'd3, 3'b000, NONE, 4'h0);
        step("add T4", 3'd4, 3'b111, DRL, 4'h0);
        step("add T5", 3'd5, 3'b000, NONE, 4'h2);
        // STA indirect
        ir = 16'hB020;
        fetch("sta");
        step("sta T3", 3'd3, 3'b111, ARL, 4'h0);
        step("sta T4", 3'd4, 3'b100, MW, 4'h0);
        // ISZ with and without the skip
        ir = 16'h6030;
        dr_zero = 1'b1;
        fetch("isz1");
        step("isz1 T3", 3'd3, 3'b000, NONE, 4'h0);
        step("isz1 T4", 3'd4, 3'b111, DRL, 4'h0);
        step("isz1 T5", 3'd5, 3'b000, DRI, 4'h0);
        step("isz1 T6", 3'd6, 3'b011, MW | PCI, 4'h0);
        dr_zero = 1'b0;
        fetch("isz0");
        step("isz0 T3", 3'd3, 3'b000, NONE, 4'h0);
        step("isz0 T4", 3'd4, 3'b111, DRL, 4'h0);
        step("isz0 T5", 3'd5, 3'b000, DRI, 4'h0);
        step("isz0 T6", 3'd6, 3'b011, MW, 4'h0);
        // BUN direct
        ir = 16'h4123;
        fetch("bun");
        step("bun T3", 3'd3, 3'b000, NONE, 4'h0);
        step("bun T4", 3'd4, 3'b001, PCL, 4'h0);
        // register-reference, flags = {ac_sign, ac_zero, e_flag}
        rref("sza z1", 16'h7004, 3'b010, PCI, 4'h0);
        rref("sza z0", 16'h7004, 3'b000, NONE, 4'h0);
        rref("cla+sza", 16'h7804, 3'b010, NONE, 4'h4);
        rref("spa pos", 16'h7010, 3'b000, PCI, 4'h0);
        rref("spa neg", 16'h7010, 3'b100, NONE, 4'h0);
        rref("sna neg", 16'h7008, 3'b100, PCI, 4'h0);
        rref("sze e0", 16'h7002, 3'b000, PCI, 4'h0);
        rref("cir+inc", 16'h70A0, 3'b000, NONE, 4'h8);
        rref("inc", 16'h7020, 3'b000, NONE, 4'hA);
        rref("cme", 16'h7100, 3'b000, NONE, 4'h7);
        rref("nop", 16'h7000, 3'b000, NONE, 4'h0);
`ifndef INTERRUPT_EN
        ir = 16'hF080;
        fetch("io nop");
        step("io nop T3", 3'd3, 3'b000, NONE, 4'h0);
`endif
        // HLT then hold for 10 cycles
        ir = 16'h7001;
        fetch("hlt");
        #2 chk("hlt pre", {20'd0, halted}, 21'd0);
        step("hlt T3", 3'd3, 3'b000, NONE, 4'h0);
        for (int k = 0; k < 10; k++) begin
            #2 chk("halt hold", obs, 21'd0);
            chk("halt flag", {20'd0, halted}, 21'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("halt cleared", {20'd0, halted}, 21'd0);
        #0;
        // reset aborts BSA at T4
        ir = 16'h5040;
        fetch("bsa");
        step("bsa T3", 3'd3, 3'b000, NONE, 4'h0);
        #2 chk("bsa T4", obs, {3'd4, 3'b010, MW | ARI, 4'h0});
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        step("abort T0", 3'd0, 3'b010, ARL, 4'h0);
        step("abort T1", 3'd1, 3'b111, IRL | PCI, 4'h0);
        step("abort T2", 3'd2, 3'b101, ARL, 4'h0);
        step("abort T3", 3'd3, 3'b000, NONE, 4'h0);
        step("bsa T4b", 3'd4, 3'b010, MW | ARI, 4'h0);
        step("bsa T5", 3'd5, 3'b001, PCL, 4'h0);
`ifdef INTERRUPT_EN
        ir = 16'hF080;
        fetch("ion");
        step("ion T3", 3'd3, 3'b000, NONE, 4'h0);
        ir = 16'h7000;
        fgi = 1'b1;
        fetch("pend");
        step("pend T3", 3'd3, 3'b000, NONE, 4'h0);
        step("RT0", 3'd0, 3'b010, ARC | TRL, 4'h0);
        step("RT1", 3'd1, 3'b110, MW | PCC, 4'h0);
        step("RT2", 3'd2, 3'b000, PCI, 4'h0);
        fetch("post");
        step("post T3", 3'd3, 3'b000, NONE, 4'h0);
        step("ien off", 3'd0, 3'b010, ARL, 4'h0);
`else
        step("final T0", 3'd0, 3'b010, ARL, 4'h0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Timing and control unit of the basic computer.
- Runs the T0..T6 sequence counter and decodes IR.
- Each cycle it drives bus_code into the bus chooser, plus the load/increment/clear strobes for AR, PC, DR, AC, IR, TR, memory write and the ALU operation select.
- Sits directly upstream of the bus chooser and the register file.

Parameters:
SC_W, 3, sequence counter width (states T0..T6; value 7 unused)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high; clears all state
ir_outdata  input  16  current IR contents
ac_sign  input  1  AC[15]
ac_zero  input  1  AC==0
e_flag  input  1  E flip-flop
dr_zero  input  1  DR==0 (after increment)
fgi  input  1  input flag (used only with INTERRUPT_EN)
fgo  input  1  output flag (used only with INTERRUPT_EN)
bus_code  output  3  bus source select: 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 MEM, 000 none
ar_ld, ar_inc, ar_clr  output  1 each  AR controls
pc_ld, pc_inc, pc_clr  output  1 each  PC controls
dr_ld, dr_inc  output  1 each  DR controls
ir_ld, tr_ld, mem_wr  output  1 each  IR load, TR load, memory write at AR
alu_op  output  4  0 NOP, 1 AND, 2 ADD, 3 XFER_DR, 4 CLA, 5 CLE, 6 CMA, 7 CME, 8 CIR, 9 CIL, A INC, B INP, C OUT
sc  output  3  current timing state (debug)
halted  output  1  HLT executed

Behaviour:
- Outputs are combinational from sc, i_ff, ir_outdata and flags; targets update on the next clk edge.
- Any output not named for a state is 0; bus_code=000.
- Reset: sc=0, i_ff=0, halted=0 (plus ien=0, r_ff=0). Reset mid-instruction aborts it; next cycle is T0.
- sc increments each cycle; "SC<-0" returns it to T0 next edge.
- halted=1: sc held at 0, all strobes 0, until reset.
- T0: bus=010, ar_ld.
- T1: bus=111, ir_ld, pc_inc.
- T2: bus=101, ar_ld; i_ff<=IR[15]. Latch D=IR[14:12].
- T3:
  - D!=7 with i_ff=1: bus=111, ar_ld.
  - D!=7 with i_ff=0: idle.
  - D=7 with i_ff=0: register-reference; priority from IR[11] down to IR[0], only the highest set bit acts. Bits: CLA alu4, CLE alu5, CMA alu6, CME alu7, CIR alu8, CIL alu9, INC aluA. SPA: pc_inc if !ac_sign. SNA: pc_inc if ac_sign. SZA: pc_inc if ac_zero. SZE: pc_inc if !e_flag. HLT: halted<=1. IR[11:0]==0 is a NOP. Then SC<-0.
  - D=7 with i_ff=1: I/O per Optional Feature. Then SC<-0.
- AND/ADD/LDA (D=0/1/2):
  - T4: bus=111, dr_ld.
  - T5: alu 1/2/3, then SC<-0.
- STA (D=3), T4: bus=100, mem_wr, SC<-0.
- BUN (D=4), T4: bus=001, pc_ld, SC<-0.
- BSA (D=5):
  - T4: bus=010, mem_wr, ar_inc.
  - T5: bus=001, pc_ld, SC<-0.
- ISZ (D=6):
  - T4: bus=111, dr_ld.
  - T5: dr_inc.
  - T6: bus=011, mem_wr, pc_inc if dr_zero, SC<-0.
- sc never exceeds 6. If sc reaches 7 by any fault, the next state is 0.

Optional Feature:
- Macro: INTERRUPT_EN.
- Without the macro:
  - D=7 with i_ff=1 is a NOP, SC<-0.
  - fgi and fgo are ignored.
  - Bus code 110 is never driven.
- With the macro, added state: ien and r_ff.
- I/O instructions (same IR[11:6] priority scheme):
  - INP: alu B.
  - OUT: alu C.
  - SKI: pc_inc if fgi.
  - SKO: pc_inc if fgo.
  - ION: ien<=1.
  - IOF: ien<=0.
- r_ff<=1 at any edge where sc is not 0, 1 or 2 and ien & (fgi|fgo).
- With r_ff=1, T0..T2 are replaced by the interrupt cycle:
  - RT0: ar_clr, bus=010, tr_ld.
  - RT1: bus=110, mem_wr, pc_clr.
  - RT2: pc_inc, ien<=0, r_ff<=0, SC<-0.
- Reset clears ien and r_ff. HLT still takes precedence; no interrupts while halted.

Test Plan:
- Reset, then IR=16'h2010 (LDA direct) over T0..T5 -> bus sequence 010,111,101,000,111,000; alu_op=3 at T5; sc returns to 0.
- IR=16'hB020 (STA indirect) -> T3 bus=111 with ar_ld; T4 bus=100 with mem_wr; instruction takes 5 cycles.
- IR=16'h6030 (ISZ) with dr_zero=1 at T6 -> bus=011, mem_wr and pc_inc all asserted at T6.
- IR=16'h7004 (SZA): ac_zero=1 gives pc_inc at T3, ac_zero=0 gives none. IR=16'h7001 (HLT) gives halted=1 and sc stays 0 for 10 cycles. Reset then clears halted.
- Reset asserted at T4 of BSA (IR=16'h5040) -> next cycle sc=0, mem_wr=0, bus_code=010.
- With INTERRUPT_EN: ION (16'hF080), then fgi=1 -> after the current instruction, RT0/RT1/RT2 give bus 010+ar_clr+tr_ld, then 110+mem_wr+pc_clr, then pc_inc; ien ends at 0.
